rep_sequencer: RTL
==================

# rep_sequencer

Iteration controller for REP/REPE/REPNE-prefixed string instructions in the 8086 core. It latches the initial CX value and the prefix mode, then issues one string-iteration request at a time to the string microcode. After each iteration it decrements CX, writes the result back, and evaluates termination: CX exhausted, ZF condition for CMPS/SCAS, or a pending interrupt. It sits between the microcode sequencer, which starts it, and the register file and flags, whose CX and ZF it uses.

## Interface
No parameters.
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a string instruction; sampled only in IDLE
- rep_mode  in  2  latched on start: 0 none, 1 REP, 2 REPE/REPZ, 3 REPNE/REPNZ
- zf_sensitive  in  1  latched on start; 1 for CMPS/SCAS; ZF test applies only when set
- cx_in  in  16  initial CX, latched on start
- iter_done  in  1  one-cycle pulse from the string microcode marking the end of an iteration; honoured only in WAIT
- zf  in  1  ZF value, valid in the cycle iter_done is high
- irq_pending  in  1  unmasked interrupt or NMI pending
- abort  in  1  synchronous flush, e.g. a fault inside an iteration
- iter_start  out  1  one-cycle pulse to begin one iteration
- cx_out  out  16  updated CX value
- cx_wr  out  1  one-cycle write strobe for cx_out into CX
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the instruction completed normally
- suspended  out  1  one-cycle pulse when the instruction stops for an interrupt; the microcode rewinds IP to the prefix

## Operation
- States: IDLE, ISSUE, WAIT.
  - IDLE: start=1 latches rep_mode, zf_sensitive and cx_in into the internal count.
    - rep_mode≠0 with cx_in=0: pulse done next cycle, stay IDLE. No iteration and no cx_wr.
    - Otherwise go to ISSUE.
  - ISSUE: pulse iter_start for one cycle, go to WAIT.
  - WAIT: hold until iter_done=1, then apply the rules below.
- On iter_done with rep_mode=0: pulse done, go to IDLE. No cx_wr.
- On iter_done with rep_mode≠0:
  - Set count = count−1 and cx_out = count−1, and pulse cx_wr. The count is never decremented from 0, so it never wraps.
  - The instruction terminates if any of these hold:
    - the new count is 0;
    - zf_sensitive=1, rep_mode=2 and zf=0;
    - zf_sensitive=1, rep_mode=3 and zf=1.
  - On termination: pulse done, go to IDLE.
  - Otherwise, if irq_pending=1: pulse suspended, go to IDLE.
  - Otherwise: go to ISSUE.
- Priorities:
  - abort beats everything: next state IDLE, with no done, suspended, cx_wr or iter_start. A cx_wr already issued is not retracted.
  - Termination beats irq_pending: done, not suspended.
  - start while busy is ignored.
  - iter_done outside WAIT is ignored.
- irq_pending is sampled only at iteration boundaries, never mid-iteration.
- Asynchronous reset mid-operation returns to IDLE immediately with all outputs 0; the partially executed instruction is discarded.

## Timing
- All outputs are registered.
- Reset values: iter_start=0, cx_out=16'h0000, cx_wr=0, busy=0, done=0, suspended=0, state=IDLE.
- Start and first iteration: start high in cycle T gives busy=1 and iter_start=1 in T+1, with state WAIT from T+2.
- Iteration boundary: iter_done high in cycle D gives cx_out and cx_wr in D+1. In the same cycle D+1 there is exactly one of:
  - iter_start, when continuing (state goes ISSUE→WAIT, so iter_start is high in D+1 only);
  - done or suspended, with busy=0.
- Back-to-back rate: with iter_done returned in the cycle after iter_start, one iteration every 2 cycles.
- Zero-count REP: start in T gives done in T+1, and busy stays 0.
- abort high in cycle A gives busy=0 in A+1.
- A new start is accepted in the cycle done or suspended is high.

## Test plan
- REP MOVS, cx_in=3, iter_done returned 1 cycle after each iter_start:
  - 3 iter_start pulses;
  - cx_wr with cx_out=2, 1, 0;
  - done in the cycle of the last cx_wr;
  - start to done takes 7 cycles.
- REP, cx_in=0 → done at T+1; no iter_start, no cx_wr; busy stays 0.
- REPE CMPS, cx_in=5, zf=1,1,0 on successive iter_done → 3 iterations, final cx_out=2, done. Same stimulus with zf_sensitive=0 → runs to cx_out=0.
- REP, cx_in=16'hFFFF, irq_pending raised during iteration 2 → after that iter_done: cx_out=16'hFFFD, suspended=1, done=0. A restart with cx_in=16'hFFFD resumes normally.
- Simultaneous events:
  - irq_pending=1 on the iteration that brings the count to 0 → done=1, suspended=0.
  - abort together with iter_done → next cycle busy=0 and no cx_wr.
- rep_mode=0, cx_in=7 → exactly one iter_start, then done, no cx_wr. Assert reset_n=0 mid-WAIT on a REP run → all outputs 0 immediately, and a new start after release behaves normally.

Source files
------------

// File: rtl/rep_sequencer_if.sv
// Handshake bundle between the microcode sequencer, the string microcode and
// the REP iteration controller.
interface rep_sequencer_if;
  logic        start;
  logic [1:0]  rep_mode;
  logic        zf_sensitive;
  logic [15:0] cx_in;
  logic        iter_done;
  logic        zf;
  logic        irq_pending;
  logic        abort;
  logic        iter_start;
  logic [15:0] cx_out;
  logic        cx_wr;
  logic        busy;
  logic        done;
  logic        suspended;

  modport slave (
    input  start, rep_mode, zf_sensitive, cx_in, iter_done, zf, irq_pending, abort,
    output iter_start, cx_out, cx_wr, busy, done, suspended
  );

  modport master (
    output start, rep_mode, zf_sensitive, cx_in, iter_done, zf, irq_pending, abort,
    input  iter_start, cx_out, cx_wr, busy, done, suspended
  );
endinterface

// File: rtl/rep_sequencer.sv
// REP/REPE/REPNE iteration controller: issues one string iteration at a time,
// counts CX down and decides between continue, complete and interrupt-suspend.
module rep_sequencer (
  input  logic          clk,
  input  logic          reset_n,
  rep_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic        zfs_q, zfs_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cx_out_q, cx_out_d;
  logic        iter_start_q, iter_start_d;
  logic        cx_wr_q, cx_wr_d;
  logic        busy_q;
  logic        done_q, done_d;
  logic        susp_q, susp_d;

  logic [15:0] cnt_dec;
  logic        term;

  // Saturating decrement: the count never wraps below zero.
  assign cnt_dec = (cnt_q == 16'd0) ? 16'd0 : cnt_q - 16'd1;
  assign term    = (cnt_dec == 16'd0) ||
                   (zfs_q && (mode_q == 2'd2) && !bus.zf) ||
                   (zfs_q && (mode_q == 2'd3) &&  bus.zf);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    zfs_d    = zfs_q;
    cnt_d    = cnt_q;
    cx_out_d = cx_out_q;
    cx_wr_d  = 1'b0;
    done_d   = 1'b0;
    susp_d   = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          mode_d = bus.rep_mode;
          zfs_d  = bus.zf_sensitive;
          cnt_d  = bus.cx_in;
          if (bus.rep_mode != 2'd0 && bus.cx_in == 16'd0) done_d  = 1'b1;
          else                                            state_d = ISSUE;
        end
        ISSUE: state_d = WAIT;
        WAIT: if (bus.iter_done) begin
          if (mode_q == 2'd0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d    = cnt_dec;
            cx_out_d = cnt_dec;
            cx_wr_d  = 1'b1;
            // Termination outranks a pending interrupt.
            if (term) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (bus.irq_pending) begin
              susp_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = ISSUE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    iter_start_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mode_q       <= 2'd0;
      zfs_q        <= 1'b0;
      cnt_q        <= 16'd0;
      cx_out_q     <= 16'd0;
      iter_start_q <= 1'b0;
      cx_wr_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      susp_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      zfs_q        <= zfs_d;
      cnt_q        <= cnt_d;
      cx_out_q     <= cx_out_d;
      iter_start_q <= iter_start_d;
      cx_wr_q      <= cx_wr_d;
      busy_q       <= (state_d != IDLE);
      done_q       <= done_d;
      susp_q       <= susp_d;
    end
  end

  assign bus.iter_start = iter_start_q;
  assign bus.cx_out     = cx_out_q;
  assign bus.cx_wr      = cx_wr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.suspended  = susp_q;
endmodule
